// File: rtl/ex_mdu_seq_pkg.sv
// Shared types for the EX-stage RV32M multiply/divide sequencer.
// Holds the M-extension op encodings, FSM states and the request bundle.
package ex_mdu_seq_pkg;

  localparam int MDU_XLEN = 32;
  localparam logic [6:0] FUNC7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'b000,
    MDU_MULH   = 3'b001,
    MDU_MULHSU = 3'b010,
    MDU_MULHU  = 3'b011,
    MDU_DIV    = 3'b100,
    MDU_DIVU   = 3'b101,
    MDU_REM    = 3'b110,
    MDU_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_e;

  typedef struct packed {
    mdu_op_e             func3;
    logic [4:0]          rd_addr;
    logic [MDU_XLEN-1:0] a;
    logic [MDU_XLEN-1:0] b;
  } mdu_req_t;

endpackage

// File: rtl/ex_mdu_seq_iter_core.sv
// Iterative datapath: shift-add multiply or restoring divide on unsigned magnitudes.
// One step per strobe; {hi,lo} holds the product, or remainder/quotient.
module mdu_iter_core #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              step,
  input  logic              is_div,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic [2*XLEN-1:0] product,
  output logic [XLEN-1:0]   quotient,
  output logic [XLEN-1:0]   remainder
);

  logic [XLEN-1:0] hi_q;
  logic [XLEN-1:0] lo_q;
  logic [XLEN-1:0] b_q;
  logic            div_q;

  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   shifted;
  logic            fits;
  logic [XLEN-1:0] diff;

  // The partial remainder always stays below the divisor, so the difference fits in XLEN bits.
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
    shifted = {hi_q, lo_q[XLEN-1]};
    fits    = shifted >= {1'b0, b_q};
    diff    = shifted[XLEN-1:0] - b_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
    end else if (start) begin
      hi_q  <= '0;
      lo_q  <= a;
      b_q   <= b;
      div_q <= is_div;
    end else if (step) begin
      if (div_q) begin
        hi_q <= fits ? diff : shifted[XLEN-1:0];
        lo_q <= {lo_q[XLEN-2:0], fits};
      end else begin
        hi_q <= mul_sum[XLEN:1];
        lo_q <= {mul_sum[0], lo_q[XLEN-1:1]};
      end
    end
  end

  assign product   = {hi_q, lo_q};
  assign quotient  = lo_q;
  assign remainder = hi_q;

endmodule

// File: rtl/ex_mdu_seq.sv
// EX-stage RV32M sequencer: stalls the pipe while the iterative core runs, then pulses oValid.
// Optional MDU_FAST_MUL_EN: multiplies complete in one cycle on a 33x33 signed multiplier.
module ex_mdu_seq
  import ex_mdu_seq_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int STEPS = XLEN
) (
  input  logic            iClk,
  input  logic            nRst,
  input  logic            iEn,
  input  logic            iValid,
  input  logic [2:0]      iFunc3,
  input  logic [XLEN-1:0] iA,
  input  logic [XLEN-1:0] iB,
  input  logic [4:0]      iRdAddr,
  input  logic            iFlush,
  output logic            oStall,
  output logic            oValid,
  output logic [XLEN-1:0] oResult,
  output logic [4:0]      oRdAddr,
  output logic            oBusy
);

  localparam int CW = $clog2(STEPS);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  mdu_state_e state_q, state_d;
  mdu_req_t   req;

  mdu_op_e         func3_q;
  logic [4:0]      rd_q;
  logic            neg_q;
  logic            sc_q;
  logic [XLEN-1:0] sc_val_q;
  logic [XLEN-1:0] res_q;
  logic [CW-1:0]   cnt_q;

  logic            sign_a, sign_b, a_signed, b_signed;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            neg_d, b_zero, ovf, sc_hit, fast_hit;
  logic [XLEN-1:0] sc_val, fast_val;
  logic            accept, step;

  logic [2*XLEN-1:0] product, prod_fix;
  logic [XLEN-1:0]   quotient, remainder, div_raw, div_fix, result;

  assign req = '{func3: mdu_op_e'(iFunc3), rd_addr: iRdAddr, a: iA, b: iB};

  // Operand decode: magnitudes, result sign and the cases that skip the iteration.
  always_comb begin
    sign_a   = req.a[XLEN-1];
    sign_b   = req.b[XLEN-1];
    a_signed = req.func3 inside {MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
    b_signed = req.func3 inside {MDU_MULH, MDU_DIV, MDU_REM};
    a_mag    = (a_signed && sign_a) ? -req.a : req.a;
    b_mag    = (b_signed && sign_b) ? -req.b : req.b;
    case (req.func3)
      MDU_MULH, MDU_DIV:   neg_d = sign_a ^ sign_b;
      MDU_MULHSU, MDU_REM: neg_d = sign_a;
      default:             neg_d = 1'b0;
    endcase
    b_zero = req.b == '0;
    ovf    = (req.func3 inside {MDU_DIV, MDU_REM}) &&
             (req.a == {1'b1, {(XLEN-1){1'b0}}}) && (req.b == '1);
    sc_hit = req.func3[2] && (b_zero || ovf);
    if (b_zero) sc_val = req.func3[1] ? req.a : '1;
    else        sc_val = req.func3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

`ifdef MDU_FAST_MUL_EN
  logic signed [XLEN:0]     fast_a, fast_b;
  logic signed [2*XLEN+1:0] fast_p;
  always_comb begin
    fast_a   = {a_signed & sign_a, req.a};
    fast_b   = {b_signed & sign_b, req.b};
    fast_p   = fast_a * fast_b;
    fast_hit = !req.func3[2];
    fast_val = (req.func3 == MDU_MUL) ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
  end
`else
  always_comb begin
    fast_hit = 1'b0;
    fast_val = '0;
  end
`endif

  assign accept = (state_q == MDU_IDLE) && iValid && iEn && !iFlush;
  assign step   = (state_q == MDU_CALC) && iEn && !iFlush;

  mdu_iter_core #(.XLEN(XLEN)) u_core (
    .clk       (iClk),
    .rst_n     (nRst),
    .start     (accept),
    .step      (step),
    .is_div    (req.func3[2]),
    .a         (a_mag),
    .b         (b_mag),
    .product   (product),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always_comb begin
    prod_fix = neg_q ? -product : product;
    div_raw  = func3_q[1] ? remainder : quotient;
    div_fix  = neg_q ? -div_raw : div_raw;
    if (sc_q)                      result = sc_val_q;
    else if (func3_q[2])           result = div_fix;
    else if (func3_q == MDU_MUL)   result = prod_fix[XLEN-1:0];
    else                           result = prod_fix[2*XLEN-1:XLEN];
  end

  always_ff @(posedge iClk) begin
    if (!nRst) state_q <= MDU_IDLE;
    else if (iEn) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MDU_IDLE: if (iValid && !iFlush) state_d = (sc_hit || fast_hit) ? MDU_DONE : MDU_CALC;
      MDU_CALC: begin
        if (iFlush)              state_d = MDU_IDLE;
        else if (cnt_q == LAST)  state_d = MDU_DONE;
      end
      MDU_DONE: state_d = MDU_IDLE;
      default:  state_d = MDU_IDLE;
    endcase
  end

  always_comb begin
    oStall  = ((state_q == MDU_IDLE) && iValid && !iFlush) || (state_q == MDU_CALC);
    oValid  = state_q == MDU_DONE;
    oBusy   = state_q != MDU_IDLE;
    oResult = (state_q == MDU_DONE) ? result : res_q;
    oRdAddr = rd_q;
  end

  always_ff @(posedge iClk) begin
    if (!nRst) begin
      func3_q  <= MDU_MUL;
      rd_q     <= '0;
      neg_q    <= 1'b0;
      sc_q     <= 1'b0;
      sc_val_q <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
    end else if (iEn) begin
      if (accept) begin
        func3_q  <= req.func3;
        rd_q     <= req.rd_addr;
        neg_q    <= neg_d;
        sc_q     <= sc_hit || fast_hit;
        sc_val_q <= sc_hit ? sc_val : fast_val;
        cnt_q    <= '0;
      end else if (step) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (state_q == MDU_DONE) res_q <= result;
    end
  end

endmodule

// File: tb/tb_ex_mdu_seq.sv
// Bench for ex_mdu_seq: directed vector table, flush/hold/reset sequences, randomized ops vs a reference model.
module tb_ex_mdu_seq;

  logic        iClk = 1'b0;
  logic        nRst, iEn, iValid, iFlush;
  logic [2:0]  iFunc3;
  logic [31:0] iA, iB;
  logic [4:0]  iRdAddr;
  logic        oStall, oValid, oBusy;
  logic [31:0] oResult;
  logic [4:0]  oRdAddr;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  ex_mdu_seq #(.XLEN(32), .STEPS(32)) dut (
    .iClk(iClk), .nRst(nRst), .iEn(iEn), .iValid(iValid), .iFunc3(iFunc3),
    .iA(iA), .iB(iB), .iRdAddr(iRdAddr), .iFlush(iFlush), .oStall(oStall),
    .oValid(oValid), .oResult(oResult), .oRdAddr(oRdAddr), .oBusy(oBusy)
  );

  always #5 iClk = ~iClk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: RV32M semantics from 64-bit integer arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (f)
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(sa / sb);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2]) return MUL_LAT;
    if (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
    return 33;
  endfunction

  // Issue one op, wait for its result; optionally drop iEn for hold_len cycles from cycle hold_at.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input int hold_at, input int hold_len,
                       output logic [31:0] res, output logic [4:0] rdo, output int lat,
                       output logic stall_ok);
    @(negedge iClk);
    iValid = 1'b1; iFunc3 = f; iA = a; iB = b; iRdAddr = rd;
    #1;
    stall_ok = (oStall === 1'b1);
    @(posedge iClk);
    #1;
    iValid = 1'b0; iA = $urandom; iB = $urandom; iRdAddr = 5'($urandom);
    lat = 1;
    while (lat < 200) begin
      @(negedge iClk);
      if (oValid === 1'b1) break;
      if (oStall !== 1'b1) stall_ok = 1'b0;
      iEn = !(lat >= hold_at && lat < hold_at + hold_len);
      @(posedge iClk);
      lat++;
    end
    res = oResult;
    rdo = oRdAddr;
    if (oStall !== 1'b0) stall_ok = 1'b0;
    iEn = 1'b1;
    @(posedge iClk);
  endtask

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] res, exp_res;
    logic [4:0]  rdo;
    int          lat;
    logic        stall_ok, saw_valid;
    logic [2:0]  f;
    logic [31:0] a, b;

    vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT};
    vecs[1]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT};
    vecs[2]  = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, MUL_LAT};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
    vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        33};
    vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         33};
    vecs[8]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
    vecs[9]  = '{3'd7, 32'd5,          32'd0,         32'd5,         1};
    vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1};
    vecs[12] = '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};

    nRst = 1'b0; iEn = 1'b1; iValid = 1'b0; iFlush = 1'b0;
    iFunc3 = '0; iA = '0; iB = '0; iRdAddr = '0;
    repeat (2) @(posedge iClk);
    @(negedge iClk);
    check("reset_valid", 32'(oValid), 32'd0);
    check("reset_result", oResult, 32'd0);
    check("reset_rd", 32'(oRdAddr), 32'd0);
    check("reset_busy", 32'(oBusy), 32'd0);
    check("reset_stall", 32'(oStall), 32'd0);
    nRst = 1'b1;

    for (int i = 0; i < 13; i++) begin
      do_op(vecs[i].f, vecs[i].a, vecs[i].b, 5'(i + 1), 0, 0, res, rdo, lat, stall_ok);
      check($sformatf("vec%0d_result", i), res, vecs[i].res);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_stall", i), 32'(stall_ok), 32'd1);
      check($sformatf("vec%0d_rd", i), 32'(rdo), 32'(i + 1));
    end

    // Flush with iValid in IDLE: op must be rejected.
    @(negedge iClk);
    iValid = 1'b1; iFlush = 1'b1; iFunc3 = 3'd5; iA = 32'd5; iB = 32'd7; iRdAddr = 5'd3;
    #1;
    check("flush_idle_stall", 32'(oStall), 32'd0);
    @(posedge iClk);
    #1;
    iValid = 1'b0; iFlush = 1'b0;
    @(negedge iClk);
    check("flush_idle_busy", 32'(oBusy), 32'd0);

    // DIV 1000/3 flushed at counter 10, then MUL 6*7.
    @(negedge iClk);
    iValid = 1'b1; iFunc3 = 3'd4; iA = 32'd1000; iB = 32'd3; iRdAddr = 5'd9;
    @(posedge iClk);
    #1;
    iValid = 1'b0;
    saw_valid = 1'b0;
    repeat (10) begin
      @(negedge iClk);
      if (oValid) saw_valid = 1'b1;
      @(posedge iClk);
    end
    @(negedge iClk);
    check("flush_calc_busy_before", 32'(oBusy), 32'd1);
    iFlush = 1'b1;
    @(posedge iClk);
    #1;
    iFlush = 1'b0;
    @(negedge iClk);
    check("flush_calc_busy_after", 32'(oBusy), 32'd0);
    check("flush_calc_valid", 32'(oValid | saw_valid), 32'd0);
    do_op(3'd0, 32'd6, 32'd7, 5'd4, 0, 0, res, rdo, lat, stall_ok);
    check("after_flush_result", res, 32'd42);
    check("after_flush_latency", 32'(lat), 32'(MUL_LAT));

    // Enable dropped for 5 cycles mid-CALC.
    do_op(3'd5, 32'd1000, 32'd7, 5'd12, 5, 5, res, rdo, lat, stall_ok);
    check("hold_result", res, 32'd142);
    check("hold_latency", 32'(lat), 32'd38);
    check("hold_stall", 32'(stall_ok), 32'd1);

    // Randomized ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
        3: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: ;
      endcase
      exp_q.push_back(ref_model(f, a, b));
      do_op(f, a, b, 5'(i), 0, 0, res, rdo, lat, stall_ok);
      exp_res = exp_q.pop_front();
      check($sformatf("rand%0d_f%0d_result", i, f), res, exp_res);
      check($sformatf("rand%0d_latency", i), 32'(lat), 32'(ref_lat(f, a, b)));
    end

    // Reset mid-CALC clears outputs and returns to IDLE.
    @(negedge iClk);
    iValid = 1'b1; iFunc3 = 3'd5; iA = 32'd1000; iB = 32'd7; iRdAddr = 5'd17;
    @(posedge iClk);
    #1;
    iValid = 1'b0;
    repeat (8) @(posedge iClk);
    @(negedge iClk);
    check("midreset_busy_before", 32'(oBusy), 32'd1);
    nRst = 1'b0;
    @(posedge iClk);
    #1;
    check("midreset_valid", 32'(oValid), 32'd0);
    check("midreset_result", oResult, 32'd0);
    check("midreset_rd", 32'(oRdAddr), 32'd0);
    check("midreset_busy", 32'(oBusy), 32'd0);
    check("midreset_stall", 32'(oStall), 32'd0);
    @(negedge iClk);
    nRst = 1'b1;
    do_op(3'd7, 32'd100, 32'd7, 5'd21, 0, 0, res, rdo, lat, stall_ok);
    check("post_reset_result", res, 32'd2);
    check("post_reset_latency", 32'(lat), 32'd33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
